// File: rtl/alu_seq.sv
// Registered execute-stage ALU with an iterative shift-add multiplier and a
// held NZCV status register. Single-cycle ops return one cycle after accept;
// MUL/MLA spend WIDTH cycles in the engine plus one write-back cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  request handshake (exec_cmd, in1, in2, in3, c_in, s_bit)
//   out_valid/ready result handshake; out holds the registered result
//   nzcv            status register {N,Z,C,V}
//   busy            multiply engine running
module alu_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exec_cmd,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             c_in,
    input  logic             s_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       nzcv,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   out_d;
    logic [3:0]         nzcv_d;
    logic               out_valid_d;
    logic [WIDTH-1:0]   acc, acc_d;
    logic [WIDTH-1:0]   mcand, mcand_d;
    logic [WIDTH-1:0]   mplier, mplier_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               mul_s, mul_s_d;

    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     c_ext;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && ((exec_cmd == OP_MUL) || (exec_cmd == OP_MLA));
    assign busy     = (state == S_MUL);

    assign a_ext = {1'b0, in1};
    assign b_ext = {1'b0, in2};
    assign c_ext = {{WIDTH{1'b0}}, c_in};

    // Single-cycle result on WIDTH+1 bits; bit WIDTH is carry (add) or borrow (sub).
    always_comb begin
        alu_res = a_ext;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (exec_cmd)
            OP_MOV: alu_res = b_ext;
            OP_MVN: alu_res = {1'b0, ~in2};
            OP_ADD, OP_ADC: begin
                alu_res = (exec_cmd == OP_ADC) ? (a_ext + b_ext + c_ext) : (a_ext + b_ext);
                alu_c   = alu_res[WIDTH];
                alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_res[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                alu_res = (exec_cmd == OP_SBC) ? (a_ext - b_ext - c_ext) : (a_ext - b_ext);
                alu_c   = alu_res[WIDTH];
                alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_res[WIDTH-1] == in2[WIDTH-1]);
            end
            OP_AND:  alu_res = {1'b0, in1 & in2};
            OP_ORR:  alu_res = {1'b0, in1 | in2};
            OP_EOR:  alu_res = {1'b0, in1 ^ in2};
            default: alu_res = a_ext;
        endcase
    end

    // Next-state and datapath: IDLE executes or launches multiply, MUL iterates, DONE writes back.
    always_comb begin
        state_d     = state;
        out_d       = out;
        nzcv_d      = nzcv;
        out_valid_d = out_valid && !out_ready;
        acc_d       = acc;
        mcand_d     = mcand;
        mplier_d    = mplier;
        cnt_d       = cnt;
        mul_s_d     = mul_s;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d  = S_MUL;
                        acc_d    = (exec_cmd == OP_MLA) ? in3 : '0;
                        mcand_d  = in1;
                        mplier_d = in2;
                        cnt_d    = '0;
                        mul_s_d  = s_bit;
                    end else begin
                        out_d       = alu_res[WIDTH-1:0];
                        out_valid_d = 1'b1;
                        if (s_bit) begin
                            nzcv_d = {alu_res[WIDTH-1], (alu_res[WIDTH-1:0] == '0), alu_c, alu_v};
                        end
                    end
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first; multiplicand shifts left in step.
                if (mplier[0]) begin
                    acc_d = acc + mcand;
                end
                mcand_d  = {mcand[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier[WIDTH-1:1]};
                cnt_d    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Output is known empty here: a multiply is only accepted while it drains.
                out_d       = acc;
                out_valid_d = 1'b1;
                if (mul_s) begin
                    nzcv_d = {acc[WIDTH-1], (acc == '0), nzcv[1:0]};
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out       <= '0;
            nzcv      <= 4'b0000;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            mul_s     <= 1'b0;
        end else begin
            state     <= state_d;
            out       <= out_d;
            nzcv      <= nzcv_d;
            out_valid <= out_valid_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
            cnt       <= cnt_d;
            mul_s     <= mul_s_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit instance checked through a result
// scoreboard plus explicit timing checks, and an 8-bit instance with the
// multiplier disabled for width-boundary and fallback-opcode checks.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] out;
        logic [3:0]  nzcv;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  exec_cmd;
    logic [31:0] in1, in2, in3;
    logic        c_in;
    logic        s_bit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  nzcv;
    logic        busy;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_exec_cmd;
    logic [7:0]  b_in1, b_in2, b_in3;
    logic        b_c_in;
    logic        b_s_bit;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out;
    logic [3:0]  b_nzcv;
    logic        b_busy;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [3:0]  model_nzcv = 4'b0000;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .exec_cmd(exec_cmd), .in1(in1), .in2(in2), .in3(in3),
        .c_in(c_in), .s_bit(s_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .nzcv(nzcv), .busy(busy)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .exec_cmd(b_exec_cmd), .in1(b_in1), .in2(b_in2), .in3(b_in3),
        .c_in(b_c_in), .s_bit(b_s_bit),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .nzcv(b_nzcv), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model using 64-bit arithmetic on zero-extended operands.
    function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a, b, c3,
                                   input logic cin, s, input logic [3:0] nz);
        logic [63:0] r, ae, be;
        logic        c, v;
        exp_t        e;
        ae = {32'd0, a};
        be = {32'd0, b};
        c  = 1'b0;
        v  = 1'b0;
        case (cmd)
            4'b0001: r = be;
            4'b1001: r = {32'd0, ~b};
            4'b0010: begin r = ae + be; c = r[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0011: begin r = ae + be + {63'd0, cin}; c = r[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0100: begin r = ae - be; c = r[32]; v = (a[31] != b[31]) && (r[31] == b[31]); end
            4'b0101: begin r = ae - be - {63'd0, cin}; c = r[32]; v = (a[31] != b[31]) && (r[31] == b[31]); end
            4'b0110: r = {32'd0, a & b};
            4'b0111: r = {32'd0, a | b};
            4'b1000: r = {32'd0, a ^ b};
            4'b1010: r = ae * be;
            4'b1011: r = ae * be + {32'd0, c3};
            default: r = ae;
        endcase
        e.out = r[31:0];
        if (!s)
            e.nzcv = nz;
        else if (cmd == 4'b1010 || cmd == 4'b1011)
            e.nzcv = {r[31], (r[31:0] == 32'd0), nz[1:0]};
        else
            e.nzcv = {r[31], (r[31:0] == 32'd0), c, v};
        return e;
    endfunction

    // Present a request and hold it until accepted; n = negedges sampled before the accept edge.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, b, c3,
                         input logic cin, s, output int n);
        logic ok;
        exp_t e;
        exec_cmd = cmd; in1 = a; in2 = b; in3 = c3; c_in = cin; s_bit = s;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
        if (ok) begin
            e = model(cmd, a, b, c3, cin, s, model_nzcv);
            sb.push_back(e);
            model_nzcv = e.nzcv;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each result at the cycle it is consumed.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out", 64'(out), 64'(mon_e.out));
                chk("nzcv", 64'(nzcv), 64'(mon_e.nzcv));
            end
        end
    end

    initial begin
        logic [3:0] ops [11];
        int n;
        ops = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0001,
                4'b1001, 4'b0000, 4'b1111, 4'b0010, 4'b0100};

        rst = 1'b1; in_valid = 1'b0; exec_cmd = 4'd0; in1 = '0; in2 = '0; in3 = '0;
        c_in = 1'b0; s_bit = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_exec_cmd = 4'd0; b_in1 = '0; b_in2 = '0; b_in3 = '0;
        b_c_in = 1'b0; b_s_bit = 1'b0; b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_nzcv", 64'(nzcv), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Signed overflow on ADD, result one cycle after accept
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, n);
        @(negedge clk);
        chk("add_ovf_valid", 64'(out_valid), 64'd1);
        chk("add_ovf_out", 64'(out), 64'h8000_0000);
        chk("add_ovf_nzcv", 64'(nzcv), 64'(4'b1001));
        step();

        // Zero and borrow on SUB, back to back
        issue(4'b0100, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, n);
        issue(4'b0100, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, n);

        // Every single-cycle opcode plus fallback codes, random operands, s_bit alternating
        for (int i = 0; i < 11; i++) begin
            issue(ops[i], $urandom, $urandom, $urandom, 1'($urandom), 1'(i % 2), n);
        end

        // Random multiplies through the engine
        issue(4'b1010, $urandom, $urandom, 32'd0, 1'b0, 1'b1, n);
        issue(4'b1011, $urandom, $urandom, $urandom, 1'b0, 1'b1, n);
        issue(4'b1010, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, n);

        // Set C and V, then MUL keeps them and updates N/Z; exact busy window
        issue(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, n);
        issue(4'b1010, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, n);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("mul_busy", 64'(busy), 64'd1);
            chk("mul_in_ready", 64'(in_ready), 64'd0);
            chk("mul_out_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        chk("mul_done_busy", 64'(busy), 64'd0);
        chk("mul_done_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("mul_res_valid", 64'(out_valid), 64'd1);
        chk("mul_res_out", 64'(out), 64'd42);
        chk("mul_res_nzcv", 64'(nzcv), 64'(4'b0011));
        step();

        // MLA wraps; a queued request waits out the whole multiply
        issue(4'b1011, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b0, 1'b1, n);
        issue(4'b0010, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, n);
        chk("mla_holdoff_cycles", 64'(n), 64'd34);
        repeat (3) step();

        // Back-pressure holds result and blocks input; release accepts on the same edge
        out_ready = 1'b0;
        issue(4'b0010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out", 64'(out), 64'd3);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        out_ready = 1'b1;
        issue(4'b0100, 32'd10, 32'd4, 32'd0, 1'b0, 1'b1, n);
        chk("bp_release_cycles", 64'(n), 64'd1);

        // Reset in multiply cycle 10 drops the op
        issue(4'b0100, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, n);
        issue(4'b1010, 32'd123, 32'd456, 32'd0, 1'b0, 1'b1, n);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_nzcv = 4'b0000;
        @(negedge clk);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_nzcv", 64'(nzcv), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (40) step();
        chk("abort_no_result", 64'(out_valid), 64'd0);

        // 8-bit instance: carry out to zero, and MUL/MLA codes fall back to pass-in1
        b_exec_cmd = 4'b0010; b_in1 = 8'hFF; b_in2 = 8'h01; b_s_bit = 1'b1; b_in_valid = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w8_add_out", 64'(b_out), 64'd0);
        chk("w8_add_nzcv", 64'(b_nzcv), 64'(4'b0110));
        chk("w8_add_valid", 64'(b_out_valid), 64'd1);
        step();
        b_exec_cmd = 4'b1010; b_in1 = 8'h5A; b_in2 = 8'h03; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w8_nomul_out", 64'(b_out), 64'h5A);
        chk("w8_nomul_nzcv", 64'(b_nzcv), 64'(4'b0000));
        chk("w8_nomul_busy", 64'(b_busy), 64'd0);
        step();
        b_exec_cmd = 4'b1011; b_in1 = 8'h81; b_in2 = 8'h02; b_in3 = 8'h05; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w8_nomla_out", 64'(b_out), 64'h81);
        chk("w8_nomla_nzcv", 64'(b_nzcv), 64'(4'b1000));
        step();

        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
